piano_key_renderer: RTL and testbench

PIANO_KEY_RENDERER -- requirements
Module: piano_key_renderer

---
 rtl/piano_key_renderer.sv | 113 +++++++++++
 tb/tb_piano_key_renderer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_key_renderer.sv
// Raster-scanned piano keyboard renderer: 8 white and 5 black keys, one pixel per clock.
// Key levels are synchronised and latched once per frame so the picture never tears.
module piano_key_renderer #(
    parameter int unsigned H_RES = 160,
    parameter int unsigned V_RES = 120,
    parameter int unsigned KEY_W = 20,
    parameter int unsigned BLK_W = 12,
    parameter int unsigned BLK_H = 70
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [12:0] key_pressed,
    output logic [2:0]  colour,
    output logic [7:0]  pix_x,
    output logic [6:0]  pix_y,
    output logic        frame_start
);

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLK_ON = 3'b101;
    localparam logic [2:0] COL_WHT_ON = 3'b110;
    localparam logic [2:0] COL_WHITE  = 3'b111;

    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic [12:0] key_meta_q, key_sync_q;
    logic [12:0] key_frame_q, key_frame_d;
    logic        x_wrap, y_wrap, frame_wrap;

    logic [31:0] px, py, key_idx;
    logic [4:0]  blk_keys;
    logic [7:0]  white_keys;
    logic        blk_hit, blk_on;

    // Black keys sit on white-key boundaries 1,2,4,5,6 (no key between E/F and B/C).
    function automatic int unsigned boundary(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 5;
            default: return 6;
        endcase
    endfunction

    assign x_wrap     = (x_q == 8'(H_RES - 1));
    assign y_wrap     = (y_q == 7'(V_RES - 1));
    assign frame_wrap = x_wrap && y_wrap;

    assign x_d = x_wrap ? '0 : x_q + 8'd1;
    assign y_d = x_wrap ? (y_wrap ? '0 : y_q + 7'd1) : y_q;

    // The colour register is loaded with the next pixel, so the frame latch must be
    // visible to the colour logic on the same edge that returns the scan to (0,0).
    assign key_frame_d = frame_wrap ? key_sync_q : key_frame_q;
    assign blk_keys    = key_frame_d[12:8];
    assign white_keys  = key_frame_d[7:0];

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        px       = 32'(x_d);
        py       = 32'(y_d);
        key_idx  = px / KEY_W;
        blk_hit  = 1'b0;
        blk_on   = 1'b0;
        colour_d = COL_WHITE;

        for (int k = 0; k < 5; k++) begin
            if (py < BLK_H &&
                px + BLK_W / 2 >= KEY_W * boundary(k) &&
                px < KEY_W * boundary(k) + BLK_W / 2) begin
                blk_hit = 1'b1;
                blk_on  = blk_keys[3'(k)];
            end
        end

        if (blk_hit) begin
            colour_d = blk_on ? COL_BLK_ON : COL_BLACK;
        end else if (px % KEY_W == 0) begin
            colour_d = COL_BLACK;
        end else if (key_idx < 32'd8 && white_keys[key_idx[2:0]]) begin
            colour_d = COL_WHT_ON;
        end else begin
            colour_d = COL_WHITE;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= COL_BLACK;
            key_meta_q  <= '0;
            key_sync_q  <= '0;
            key_frame_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            key_meta_q  <= key_pressed;
            key_sync_q  <= key_meta_q;
            key_frame_q <= key_frame_d;
        end
    end

    assign colour      = colour_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign frame_start = (x_q == 8'd0) && (y_q == 7'd0);

endmodule

// File: tb/tb_piano_key_renderer.sv
// Self-checking bench for piano_key_renderer: directed keyboard scenarios plus random
// key traffic compared against a frame-level model of the expected keyboard image.
module tb_piano_key_renderer;

    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int KEY_W = 20;
    localparam int BLK_W = 12;
    localparam int BLK_H = 70;
    localparam int FRAME = H_RES * V_RES;

    logic        clock       = 1'b0;
    logic        resetn      = 1'b0;
    logic [12:0] key_pressed = '0;
    logic [2:0]  colour;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    // Model: clock edges since reset release, recent key samples, the key set on screen.
    int          cyc       = 0;
    logic [12:0] hist[$];
    logic [12:0] exp_frame = '0;
    int          fs_seen   = 0;
    int          fs_last   = -1;
    int          fs_gap    = 0;

    piano_key_renderer #(
        .H_RES(H_RES), .V_RES(V_RES), .KEY_W(KEY_W), .BLK_W(BLK_W), .BLK_H(BLK_H)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_pressed (key_pressed),
        .colour      (colour),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2:0] ref_colour(input int x, input int y, input logic [12:0] k);
        int b;
        for (int j = 0; j < 5; j++) begin
            b = (j < 2) ? j + 1 : j + 2;
            if (y < BLK_H && x >= KEY_W * b - BLK_W / 2 && x <= KEY_W * b + BLK_W / 2 - 1)
                return k[8 + j] ? 3'b101 : 3'b000;
        end
        if (x % KEY_W == 0) return 3'b000;
        return k[x / KEY_W] ? 3'b110 : 3'b111;
    endfunction

    function automatic int exp_x();
        return (cyc % FRAME) % H_RES;
    endfunction

    function automatic int exp_y();
        return (cyc % FRAME) / H_RES;
    endfunction

    task automatic model_reset();
        cyc       = 0;
        hist.delete();
        exp_frame = '0;
        fs_last   = -1;
    endtask

    // One clock: update the model with the key level sampled at this edge, then settle.
    task automatic step();
        @(posedge clock);
        cyc++;
        if (cyc % FRAME == 0)
            exp_frame = (hist.size() >= 2) ? hist[hist.size() - 2] : 13'h0;
        hist.push_back(key_pressed);
        if (hist.size() > 2) hist.delete(0);
        #1;
        if (frame_start === 1'b1) begin
            fs_seen++;
            if (fs_last >= 0) fs_gap = cyc - fs_last;
            fs_last = cyc;
        end
    endtask

    task automatic run_to(input int tx, input int ty);
        for (int i = 0; i <= FRAME; i++) begin
            step();
            if (exp_x() == tx && exp_y() == ty) return;
        end
        errors++;
        checks++;
        $display("FAIL run_to: position (%0d,%0d) never reached", tx, ty);
    endtask

    task automatic test_reset();
        resetn      = 1'b0;
        key_pressed = '0;
        #12;
        checks++;
        if ({pix_x, pix_y, colour, frame_start} !== {8'd0, 7'd0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: got x=%0d y=%0d c=%b fs=%b, want x=0 y=0 c=000 fs=1",
                     pix_x, pix_y, colour, frame_start);
        end
        @(negedge clock);
        resetn = 1'b1;
        model_reset();
    endtask

    // Walks row 0 from x=1 with nothing latched; D# covers x=34..45 in the top rows.
    task automatic test_row0(input string tag);
        logic [2:0] want;
        for (int x = 1; x <= 45; x++) begin
            step();
            if (x < 14)       want = 3'b111;
            else if (x <= 25) want = 3'b000;
            else if (x <= 33) want = 3'b111;
            else              want = 3'b000;
            checks++;
            if ({pix_x, pix_y, colour, frame_start} !== {8'(x), 7'd0, want, 1'b0}) begin
                errors++;
                $display("FAIL %s x=%0d: got x=%0d y=%0d c=%b fs=%b, want c=%b fs=0",
                         tag, x, pix_x, pix_y, colour, frame_start, want);
            end
        end
    endtask

    task automatic test_no_keys_row100();
        int         px   [5] = '{80, 10, 20, 159, 0};
        int         py   [5] = '{50, 100, 100, 100, 101};
        logic [2:0] want [5] = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b000};
        for (int i = 0; i < 5; i++) begin
            run_to(px[i], py[i]);
            checks++;
            if ({pix_x, pix_y, colour} !== {8'(px[i]), 7'(py[i]), want[i]}) begin
                errors++;
                $display("FAIL no_keys(%0d,%0d): got x=%0d y=%0d c=%b, want c=%b",
                         px[i], py[i], pix_x, pix_y, colour, want[i]);
            end
            if (i == 0) key_pressed = 13'h001;
        end
    endtask

    task automatic test_frame_latch();
        run_to(10, 100);
        checks++;
        if ({pix_x, pix_y, colour} !== {8'd10, 7'd100, 3'b110}) begin
            errors++;
            $display("FAIL frame_latch: got x=%0d y=%0d c=%b, want (10,100) c=110",
                     pix_x, pix_y, colour);
        end
        key_pressed = 13'h100;
    endtask

    task automatic test_black_key();
        int         px   [5] = '{0, 20, 14, 20, 15};
        int         py   [5] = '{0, 0, 69, 70, 70};
        logic [2:0] want [5] = '{3'b000, 3'b101, 3'b101, 3'b000, 3'b111};
        for (int i = 0; i < 5; i++) begin
            run_to(px[i], py[i]);
            checks++;
            if ({pix_x, pix_y, colour, frame_start} !== {8'(px[i]), 7'(py[i]), want[i], (i == 0)}) begin
                errors++;
                $display("FAIL black_key(%0d,%0d): got x=%0d y=%0d c=%b fs=%b, want c=%b",
                         px[i], py[i], pix_x, pix_y, colour, frame_start, want[i]);
            end
        end
    endtask

    task automatic test_all_keys();
        int         px   [4] = '{60, 80, 30, 150};
        int         py   [4] = '{10, 10, 100, 119};
        logic [2:0] want [4] = '{3'b000, 3'b101, 3'b110, 3'b110};
        int         fs0;
        key_pressed = '1;
        fs0 = fs_seen;
        for (int i = 0; i < 4; i++) begin
            run_to(px[i], py[i]);
            checks++;
            if ({pix_x, pix_y, colour} !== {8'(px[i]), 7'(py[i]), want[i]}) begin
                errors++;
                $display("FAIL all_keys(%0d,%0d): got x=%0d y=%0d c=%b, want c=%b",
                         px[i], py[i], pix_x, pix_y, colour, want[i]);
            end
        end
        checks++;
        if (fs_seen - fs0 != 1 || fs_gap != FRAME) begin
            errors++;
            $display("FAIL frame_period: pulses=%0d gap=%0d, want pulses=1 gap=%0d",
                     fs_seen - fs0, fs_gap, FRAME);
        end
    endtask

    // Random key traffic across a frame wrap; every pixel is compared with the model.
    task automatic test_random();
        int         n = 0;
        logic [2:0] want;
        key_pressed = 13'($urandom);
        do begin
            step();
            want = ref_colour(exp_x(), exp_y(), exp_frame);
            checks++;
            if ({pix_x, pix_y, colour, frame_start} !==
                {8'(exp_x()), 7'(exp_y()), want, (exp_x() == 0 && exp_y() == 0)}) begin
                errors++;
                $display("FAIL random cyc=%0d: got x=%0d y=%0d c=%b fs=%b, want x=%0d y=%0d c=%b keys=%h",
                         cyc, pix_x, pix_y, colour, frame_start, exp_x(), exp_y(), want, exp_frame);
            end
            if ($urandom_range(31) == 0) key_pressed = 13'($urandom);
            n++;
        end while (!(exp_x() == 77 && exp_y() == 33) && n < FRAME);
        if (n >= FRAME) begin
            errors++;
            checks++;
            $display("FAIL random: position (77,33) never reached");
        end
    endtask

    task automatic test_reset_mid();
        key_pressed = '1;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({pix_x, pix_y, colour, frame_start} !== {8'd0, 7'd0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got x=%0d y=%0d c=%b fs=%b, want x=0 y=0 c=000 fs=1",
                     pix_x, pix_y, colour, frame_start);
        end
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        test_row0("row0_after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_row0("row0_after_reset");
        test_no_keys_row100();
        test_frame_latch();
        test_black_key();
        test_all_keys();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
